fir_output_requantizer: RTL and testbench
=========================================

Name: fir_output_requantizer

Overview:
Downstream stage of the FIR filter. It consumes the 38-bit FIR_output / output_Valid stream and does three things:
- rounds and saturates each sample to a 16-bit signed word;
- decimates by a configurable factor;
- buffers the kept samples in a small FIFO with a valid/ready output handshake toward the DAC/capture side.
It also reports sticky overflow and drop status for bench and system checking.

Parameters:
IN_WIDTH, 38, FIR output width (signed two's complement)
OUT_WIDTH, 16, output sample width (signed)
SHIFT, 15, fractional LSBs removed by rounding (1..IN_WIDTH-OUT_WIDTH)
DECIM, 2, decimation factor (1 = no decimation)
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
in_data  in  IN_WIDTH  FIR output sample
in_valid  in  1  single-cycle strobe, in_data valid this cycle
out_data  out  OUT_WIDTH  requantized sample (FIFO head)
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data when out_valid&out_ready
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a kept sample saturated
drop  out  1  sticky: a kept sample was lost because the FIFO was full

Behaviour:
- Reset (async, active-high):
  - out_valid=0, out_data=0, fifo_level=0, overflow=0, drop=0.
  - Decimation phase=0; pipeline valid cleared.
  - Takes effect immediately, mid-operation included; FIFO contents are discarded.
- Decimation:
  - The phase counter advances on every in_valid, modulo DECIM.
  - Only samples arriving at phase 0 are kept; others are ignored entirely (no status effect).
  - DECIM=1 keeps all samples.
- Stage 1 (registered, kept samples only):
  - r = in_data + 2^(SHIFT-1), signed, computed at IN_WIDTH+1 bits so it cannot wrap.
  - q = r >>> SHIFT (arithmetic shift).
- Stage 2 (registered):
  - Saturate q to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - If clipped, set overflow (sticky until reset).
  - Push the result into the FIFO.
- Latency: a kept in_valid at edge n gives out_valid=1 after edge n+2 when the FIFO was empty and no pop is pending.
- FIFO:
  - Show-ahead: out_data is the head whenever out_valid=1.
  - Pop on out_valid&out_ready.
  - Push accepted when fifo_level<FIFO_DEPTH, or when full with a pop in the same cycle; level is unchanged in that case.
  - Push when full without a pop: sample discarded, drop set (sticky), FIFO unchanged.
  - Pop when empty: ignored.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- in_valid on consecutive cycles is legal; the block never back-pressures its input.
- out_data holds its value while out_valid=0 (last head, or 0 after reset).

Optional Feature:
FIRQ_CONVERGENT_ROUND_EN
- Defined: round-half-to-even. When the dropped bits equal exactly 2^(SHIFT-1), add the half only if the pre-round bit SHIFT is 1.
- Undefined: round-half-up as described above.
- Saturation, latency and all other behaviour are identical in both builds.

Decomposition:
- Package fir_pkg holds:
  - FIR_IN_WIDTH=16 and FIR_OUT_WIDTH=38 constants, shared with the FIR block and its bench;
  - the signed sample typedefs;
  - the SAT_MAX/SAT_MIN constant functions.
- One sub-module: fir_sample_fifo, a parameterised synchronous show-ahead FIFO with push/pop/full/empty/level and the same async active-high reset.
- Rounding, saturation and decimation stay in the top module.

Test Plan (SHIFT=15, OUT_WIDTH=16, DECIM=2, FIFO_DEPTH=4 unless noted):
1. DECIM=1, out_ready=1; inputs 32768, 16384, 49152, -16384 -> outputs 1, 1, 2, 0, each 2 cycles after input; with FIRQ_CONVERGENT_ROUND_EN -> 1, 0, 2, 0.
2. DECIM=1; inputs 2^31 and -2^31 -> outputs 0x7FFF and 0x8000, overflow=1 after the first, stays 1; input 32767*32768 -> 0x7FFF with no clip.
3. out_ready=1; six back-to-back inputs k*32768, k=0..5 -> outputs 0, 2, 4 only; phase wraps correctly.
4. out_ready=0; ten inputs 32768*k -> fifo_level saturates at 4, drop=1 on the 5th kept sample; then out_ready=1 -> outputs 0, 2, 4, 6 in order, then out_valid=0.
5. FIFO full, and a kept sample arrives on the same cycle as a pop -> sample accepted, level stays 4, drop stays 0.
6. Reset asserted mid-stream with fifo_level=3 and phase=1 -> all outputs and status go to 0 immediately; the next input is kept (phase 0).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR constants, sample typedefs and saturation bound helpers used by the
// FIR block, its output requantizer and their benches.
package fir_pkg;

    localparam int FIR_IN_WIDTH  = 16;
    localparam int FIR_OUT_WIDTH = 38;

    typedef logic signed [FIR_IN_WIDTH-1:0]  fir_sample_t;
    typedef logic signed [FIR_OUT_WIDTH-1:0] fir_acc_t;

    function automatic longint SAT_MAX(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint SAT_MIN(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Show-ahead synchronous FIFO for requantized samples; the head output holds the
// last popped word while empty so downstream sees a stable value.
module fir_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] last_head;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? last_head : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            last_head <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_head <= mem[rd_ptr];
            end
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fir_output_requantizer.sv
// FIR output requantizer: decimate, round, saturate and buffer samples for the DAC side.
// Define FIRQ_CONVERGENT_ROUND_EN for round-half-to-even instead of round-half-up.
module fir_output_requantizer
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = FIR_OUT_WIDTH,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [IN_WIDTH-1:0]    in_data,
    input  logic                          in_valid,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          drop
);

    localparam int QW = IN_WIDTH + 1 - SHIFT;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [QW-1:0] Q_MAX = QW'(SAT_MAX(OUT_WIDTH));
    localparam logic signed [QW-1:0] Q_MIN = QW'(SAT_MIN(OUT_WIDTH));

    // One extra MSB keeps the half-LSB addition from wrapping at full scale.
    function automatic logic signed [QW-1:0] round_shift(input logic signed [IN_WIDTH-1:0] x);
        logic        [IN_WIDTH:0] half;
        logic signed [IN_WIDTH:0] r;
        half = (IN_WIDTH+1)'(1) << (SHIFT - 1);
`ifdef FIRQ_CONVERGENT_ROUND_EN
        if ((x[SHIFT-1:0] == half[SHIFT-1:0]) && !x[SHIFT]) begin
            half = '0;
        end
`endif
        r = $signed({x[IN_WIDTH-1], x} + half);
        return QW'(r >>> SHIFT);
    endfunction

    // MSB of the result flags that the value was clipped.
    function automatic logic [OUT_WIDTH:0] saturate(input logic signed [QW-1:0] q);
        if (q > Q_MAX) begin
            return {1'b1, Q_MAX[OUT_WIDTH-1:0]};
        end else if (q < Q_MIN) begin
            return {1'b1, Q_MIN[OUT_WIDTH-1:0]};
        end
        return {1'b0, q[OUT_WIDTH-1:0]};
    endfunction

    logic [PW-1:0]              phase;
    logic                       keep;
    logic signed [QW-1:0]       q_p1;
    logic                       vld_p1;
    logic [OUT_WIDTH:0]         sat_res;
    logic signed [OUT_WIDTH-1:0] sat_p2;
    logic                       vld_p2;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;

    assign keep      = in_valid && (phase == '0);
    assign sat_res   = saturate(q_p1);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (in_valid) begin
            phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
        end
    end

    // Stage 1: round kept samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= keep;
        end
    end

    always_ff @(posedge clk) begin
        if (keep) begin
            q_p1 <= round_shift(in_data);
        end
    end

    // Stage 2: saturate and flag status, then push to the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2   <= 1'b0;
            overflow <= 1'b0;
            drop     <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1 && sat_res[OUT_WIDTH]) begin
                overflow <= 1'b1;
            end
            if (vld_p2 && fifo_full && !pop) begin
                drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            sat_p2 <= sat_res[OUT_WIDTH-1:0];
        end
    end

    fir_sample_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (vld_p2),
        .push_data (sat_p2),
        .pop       (pop),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Directed bench for fir_output_requantizer: one DECIM=1 instance and one DECIM=2 instance.
module tb_fir_output_requantizer;

    localparam int IN_W  = 38;
    localparam int OUT_W = 16;
    localparam int LW    = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic signed [IN_W-1:0]  in_data1 = '0;
    logic                    in_valid1 = 1'b0;
    logic                    out_ready1 = 1'b1;
    logic signed [OUT_W-1:0] out_data1;
    logic                    out_valid1;
    logic [LW-1:0]           level1;
    logic                    ovf1;
    logic                    drop1;

    logic signed [IN_W-1:0]  in_data2 = '0;
    logic                    in_valid2 = 1'b0;
    logic                    out_ready2 = 1'b1;
    logic signed [OUT_W-1:0] out_data2;
    logic                    out_valid2;
    logic [LW-1:0]           level2;
    logic                    ovf2;
    logic                    drop2;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [15:0] mon2[$];

    always #5 clk = ~clk;

    fir_output_requantizer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT(15), .DECIM(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .fifo_level(level1), .overflow(ovf1), .drop(drop1)
    );

    fir_output_requantizer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT(15), .DECIM(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .fifo_level(level2), .overflow(ovf2), .drop(drop2)
    );

    // Record every accepted word of the DECIM=2 instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_valid2 && out_ready2) mon2.push_back(out_data2);
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic send1(input longint v);
        in_data1 = v[IN_W-1:0];
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
    endtask

    task automatic send2(input longint v);
        in_data2 = v[IN_W-1:0];
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
    endtask

    task automatic burst2(input int first, input int last);
        longint v;
        for (int k = first; k <= last; k++) begin
            v = longint'(k) * 32768;
            in_data2 = v[IN_W-1:0];
            in_valid2 = 1'b1;
            @(posedge clk); #1;
        end
        in_valid2 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        total_cnt++;
        if ({out_valid1, out_data1, level1, ovf1, drop1} !== '0)
            $display("FAIL reset_dut1: valid=%b data=%h level=%0d ovf=%b drop=%b required all 0",
                     out_valid1, out_data1, level1, ovf1, drop1);
        else pass_cnt++;
        total_cnt++;
        if ({out_valid2, out_data2, level2, ovf2, drop2} !== '0)
            $display("FAIL reset_dut2: valid=%b data=%h level=%0d ovf=%b drop=%b required all 0",
                     out_valid2, out_data2, level2, ovf2, drop2);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_rounding();
        longint      vin[4] = '{32768, 16384, 49152, -16384};
        logic [15:0] vexp[4];
        vexp[0] = 16'd1;
`ifdef FIRQ_CONVERGENT_ROUND_EN
        vexp[1] = 16'd0;
`else
        vexp[1] = 16'd1;
`endif
        vexp[2] = 16'd2;
        vexp[3] = 16'd0;
        do_reset();
        out_ready1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send1(vin[i]);
            total_cnt++;
            if (out_valid1 !== 1'b0)
                $display("FAIL round%0d_early1: out_valid=%b required 0", i, out_valid1);
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid1 !== 1'b0)
                $display("FAIL round%0d_early2: out_valid=%b required 0", i, out_valid1);
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid1 !== 1'b1 || out_data1 !== vexp[i])
                $display("FAIL round%0d_out: valid=%b data=%h required valid=1 data=%h",
                         i, out_valid1, out_data1, vexp[i]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        longint      vin[3] = '{longint'(32767) * 32768, longint'(1) <<< 31, -(longint'(1) <<< 31)};
        logic [15:0] vexp[3] = '{16'h7FFF, 16'h7FFF, 16'h8000};
        logic        vovf[3] = '{1'b0, 1'b1, 1'b1};
        do_reset();
        out_ready1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send1(vin[i]);
            cycles(2);
            total_cnt++;
            if (out_valid1 !== 1'b1 || out_data1 !== vexp[i])
                $display("FAIL sat%0d_out: valid=%b data=%h required valid=1 data=%h",
                         i, out_valid1, out_data1, vexp[i]);
            else pass_cnt++;
            total_cnt++;
            if (ovf1 !== vovf[i])
                $display("FAIL sat%0d_overflow: overflow=%b required %b", i, ovf1, vovf[i]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_decimation();
        logic [15:0] vexp[4] = '{16'd0, 16'd2, 16'd4, 16'd7};
        do_reset();
        out_ready2 = 1'b1;
        mon2.delete();
        burst2(0, 5);
        cycles(5);
        total_cnt++;
        if (mon2.size() != 3)
            $display("FAIL decim_count: got %0d words required 3", mon2.size());
        else pass_cnt++;
        send2(longint'(7) * 32768);
        cycles(5);
        total_cnt++;
        if (mon2.size() != 4)
            $display("FAIL decim_wrap_count: got %0d words required 4", mon2.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < mon2.size(); i++) begin
            total_cnt++;
            if (mon2[i] !== vexp[i])
                $display("FAIL decim_word%0d: got %h required %h", i, mon2[i], vexp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_fifo_full_drop();
        logic [15:0] vexp[4] = '{16'd0, 16'd2, 16'd4, 16'd6};
        do_reset();
        out_ready2 = 1'b0;
        burst2(0, 7);
        cycles(4);
        total_cnt++;
        if (level2 !== 3'd4 || drop2 !== 1'b0)
            $display("FAIL full_nodrop: level=%0d drop=%b required level=4 drop=0", level2, drop2);
        else pass_cnt++;
        burst2(8, 9);
        cycles(4);
        total_cnt++;
        if (level2 !== 3'd4 || drop2 !== 1'b1)
            $display("FAIL full_drop: level=%0d drop=%b required level=4 drop=1", level2, drop2);
        else pass_cnt++;
        mon2.delete();
        out_ready2 = 1'b1;
        cycles(8);
        total_cnt++;
        if (mon2.size() != 4)
            $display("FAIL drain_count: got %0d words required 4", mon2.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < mon2.size(); i++) begin
            total_cnt++;
            if (mon2[i] !== vexp[i])
                $display("FAIL drain_word%0d: got %h required %h", i, mon2[i], vexp[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (out_valid2 !== 1'b0 || out_data2 !== 16'd6 || level2 !== 3'd0)
            $display("FAIL drain_hold: valid=%b data=%h level=%0d required valid=0 data=0006 level=0",
                     out_valid2, out_data2, level2);
        else pass_cnt++;
    endtask

    task automatic test_pop_push_full();
        logic [15:0] vexp[5] = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd8};
        do_reset();
        out_ready2 = 1'b0;
        burst2(0, 7);
        cycles(4);
        mon2.delete();
        send2(longint'(8) * 32768);
        @(posedge clk); #1;
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        total_cnt++;
        if (level2 !== 3'd4 || drop2 !== 1'b0)
            $display("FAIL popush_level: level=%0d drop=%b required level=4 drop=0", level2, drop2);
        else pass_cnt++;
        out_ready2 = 1'b1;
        cycles(8);
        total_cnt++;
        if (mon2.size() != 5)
            $display("FAIL popush_count: got %0d words required 5", mon2.size());
        else pass_cnt++;
        for (int i = 0; i < 5 && i < mon2.size(); i++) begin
            total_cnt++;
            if (mon2[i] !== vexp[i])
                $display("FAIL popush_word%0d: got %h required %h", i, mon2[i], vexp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready2 = 1'b0;
        send2(longint'(1) <<< 31);
        send2(0);
        send2(longint'(2) * 32768);
        send2(0);
        send2(longint'(4) * 32768);
        cycles(4);
        total_cnt++;
        if (level2 !== 3'd3 || ovf2 !== 1'b1 || out_valid2 !== 1'b1)
            $display("FAIL midrst_pre: level=%0d ovf=%b valid=%b required level=3 ovf=1 valid=1",
                     level2, ovf2, out_valid2);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid2, out_data2, level2, ovf2, drop2} !== '0)
            $display("FAIL midrst_async: valid=%b data=%h level=%0d ovf=%b drop=%b required all 0",
                     out_valid2, out_data2, level2, ovf2, drop2);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready2 = 1'b1;
        send2(longint'(5) * 32768);
        cycles(2);
        total_cnt++;
        if (out_valid2 !== 1'b1 || out_data2 !== 16'd5)
            $display("FAIL midrst_phase0: valid=%b data=%h required valid=1 data=0005",
                     out_valid2, out_data2);
        else pass_cnt++;
        cycles(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_decimation();
        test_fifo_full_drop();
        test_pop_push_full();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
